csr_latch: RTL and testbench
============================

CSR_LATCH -- requirements
Module: csr_latch

Interface
REQ-001 SHALL have parameter INIT_Q, default 1'b0: value Q takes while RST is high; Qbar takes ~INIT_Q.
REQ-002 SHALL have port C, input, 1 bit: the block's one clock, used as a level-sensitive latch gate (transparent while 1).
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port S, input, 1 bit: set request, active-low.
REQ-005 SHALL have port R, input, 1 bit: reset request, active-low.
REQ-006 SHALL have port Q, output, 1 bit: latch state.
REQ-007 SHALL have port Qbar, output, 1 bit: complement of the latch state; equals ~Q except in the forbidden state.
REQ-008 SHALL have port ILL, output, 1 bit: sticky flag set when the forbidden input S=R=0 is applied while C=1.

Function
REQ-009 When C=1, RST=0, S=0, R=1, the block SHALL drive Q=1 and Qbar=0 combinationally, with no clock edge required.
REQ-010 When C=1, RST=0, S=1, R=0, the block SHALL drive Q=0 and Qbar=1.
REQ-011 When C=1, RST=0, S=1, R=1, the block SHALL hold the previous Q and Qbar.
REQ-012 When C=1, RST=0, S=0, R=0 (forbidden input), the block SHALL drive Q=1 and Qbar=1.
REQ-013 On leaving the forbidden state, by S and R rising together or by C falling while S=R=0, Q/Qbar SHALL resolve deterministically to Q=0, Qbar=1, with no oscillation or X.
REQ-014 If exactly one of S or R rises out of the forbidden state, the state SHALL follow the remaining active input per REQ-009/REQ-010.
REQ-015 When C=0, Q and Qbar SHALL hold regardless of S and R activity.
REQ-016 On the C 1->0 transition, Q/Qbar SHALL capture the values present at that instant, except as stated in REQ-013.
REQ-017 Outputs SHALL never be X or Z after the first RST assertion.
REQ-018 The implementation SHALL be race-free in zero-delay simulation and SHALL NOT rely on combinational feedback loops.

Reset
REQ-019 While RST=1, the block SHALL asynchronously force Q=INIT_Q, Qbar=~INIT_Q and ILL=0, overriding C, S and R.
REQ-020 When RST is released, outputs SHALL hold their reset values until C=1 with an active S or R.
REQ-021 If RST is released while C=1 and S or R is active, outputs SHALL take the REQ-009/REQ-010/REQ-012 value immediately.

Configuration
REQ-022 With macro CSR_LATCH_ILLEGAL_FLAG_EN defined, ILL SHALL go to 1 when C=1 and S=R=0, SHALL stay 1 until RST=1, and SHALL be ignored by the Q/Qbar logic.
REQ-023 Without CSR_LATCH_ILLEGAL_FLAG_EN, port ILL SHALL still exist, SHALL be tied constantly to 0, and no detector logic SHALL be present.

Verification
REQ-024 The bench SHALL apply RST=1 pulse, then C=1 with S=R=1 held 50 ns; required response: Q=0, Qbar=1, ILL=0.
REQ-025 With C=1, the bench SHALL apply the sequence S=0/R=1, then S=1/R=1, then S=1/R=0, then S=1/R=1, each held 50 ns; required responses in order: Q=1; Q=1 held; Q=0; Q=0 held; Qbar=~Q throughout.
REQ-026 With C=1, the bench SHALL apply S=R=0 for 50 ns, then S=R=1; required response: Q=Qbar=1 while S=R=0, then Q=0, Qbar=1; ILL=1 with the macro and 0 without it.
REQ-027 With C=0, the bench SHALL replay the full S/R sequence of REQ-025 and REQ-026; required response: Q and Qbar unchanged from their values before C fell, and ILL unchanged.
REQ-028 With Q=1, the bench SHALL assert RST while C=1 and S=0; required response: Q=0 and Qbar=1 immediately; after RST is released, Q returns to 1.

Source files
------------

// File: rtl/csr_latch.sv
// csr_latch: gated set/reset latch with active-low S/R, asynchronous
// active-high reset and deterministic recovery from the forbidden input.
// Optional sticky forbidden-input detector on ILL, enabled by defining
// CSR_LATCH_ILLEGAL_FLAG_EN; otherwise ILL is tied to 0.
module csr_latch #(
   parameter logic INIT_Q = 1'b0
) (
   input  logic C,
   input  logic RST,
   input  logic S,
   input  logic R,
   output logic Q,
   output logic Qbar,
   output logic ILL
);

   logic q_l;
   logic forb;
   logic load;

   // Forbidden input seen through an open gate; drives Q=Qbar=1 while present
   assign forb = ~RST & C & ~S & ~R;

   // Gate open with at least one request active: latch follows the inputs
   assign load = C & ~(S & R);

   // State latch; forbidden input stores 0 so any exit resolves to Q=0/Qbar=1
   always_latch begin
      if (RST) begin
         q_l <= INIT_Q;
      end else if (load) begin
         q_l <= ~S & R;
      end
   end

   // Outputs derive from the single stored bit, so no feedback loop exists
   assign Q    = q_l | forb;
   assign Qbar = ~q_l;

`ifdef CSR_LATCH_ILLEGAL_FLAG_EN
   logic ill_l;

   // Sticky forbidden-input flag, cleared only by reset
   always_latch begin
      if (RST) begin
         ill_l <= 1'b0;
      end else if (forb) begin
         ill_l <= 1'b1;
      end
   end

   assign ILL = ill_l;
`else
   assign ILL = 1'b0;
`endif

endmodule

// File: tb/tb_csr_latch.sv
// Directed bench for csr_latch with a scoreboard queue of expected outputs.
module tb_csr_latch;

   logic C;
   logic RST;
   logic S;
   logic R;
   logic Q;
   logic Qbar;
   logic ILL;

   typedef struct {
      logic [2:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

`ifdef CSR_LATCH_ILLEGAL_FLAG_EN
   localparam logic ILL_EXP = 1'b1;
`else
   localparam logic ILL_EXP = 1'b0;
`endif

   csr_latch #(.INIT_Q(1'b0)) dut (
      .C    (C),
      .RST  (RST),
      .S    (S),
      .R    (R),
      .Q    (Q),
      .Qbar (Qbar),
      .ILL  (ILL)
   );

   // Queue the expected {Q,Qbar,ILL} for the stimulus just driven
   task automatic push(input logic eq, input logic eqb, input logic eill, input string tag);
      exp_t e;
      e.val = {eq, eqb, eill};
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare against the outputs
   task automatic check();
      exp_t       e;
      logic [2:0] obs;
      obs = {Q, Qbar, ILL};
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL sb_empty observed=%b required=entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed QQbIll=%b required=%b", e.tag, obs, e.val);
         end
      end
   endtask

   // Drive one step, check right after it settles and again at the end of the 50 ns hold
   task automatic step(input logic c_v, input logic rst_v, input logic s_v, input logic r_v,
                       input logic eq, input logic eqb, input logic eill, input string tag);
      C   = c_v;
      RST = rst_v;
      S   = s_v;
      R   = r_v;
      push(eq, eqb, eill, tag);
      #1;
      check();
      push(eq, eqb, eill, {tag, "_hold"});
      #49;
      check();
   endtask

   initial begin
      C   = 1'b0;
      RST = 1'b1;
      S   = 1'b1;
      R   = 1'b1;

      // Reset state and reset overriding an open gate with a set request
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "rst_idle");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rst_override");
      // Release with gate closed: reset values hold
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rst_release_hold");
      // Gate open, no request
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "open_idle");

      // Set / hold / reset / hold
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "set");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "set_hold");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "reset_hold");

      // Forbidden input then both rise together
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ILL_EXP, "forbid");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ILL_EXP, "forbid_exit_both");

      // Only S rises out of forbidden: R remains active, Q=0
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ILL_EXP, "preset_q1");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ILL_EXP, "forbid2");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ILL_EXP, "forbid_exit_s");
      // Only R rises out of forbidden: S remains active, Q=1
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ILL_EXP, "forbid3");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, ILL_EXP, "forbid_exit_r");

      // Gate falls during forbidden input: resolves to Q=0/Qbar=1
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ILL_EXP, "forbid4");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ILL_EXP, "forbid_c_fall");

      // Gate closed holds Q=1 through the whole replayed sequence
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ILL_EXP, "pre_closed_set");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ILL_EXP, "pre_closed_idle");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ILL_EXP, "closed_capture");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ILL_EXP, "closed_s");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ILL_EXP, "closed_idle1");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ILL_EXP, "closed_r");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ILL_EXP, "closed_idle2");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ILL_EXP, "closed_forbid");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ILL_EXP, "closed_idle3");

      // Reset while Q=1 with gate open and S active, then release
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ILL_EXP, "pre_rst_set");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rst_while_set");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rst_release_set");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
